// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: instruction-memory fetch port, redirect request,
// and the decode-side head/handshake with occupancy status.
interface fetch_queue_if #(
    parameter int WIDTH    = 32,
    parameter int INST_LEN = 32,
    parameter int DEPTH    = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    pc_if;
    logic [INST_LEN-1:0] instruction_if;
    logic                redirect_valid;
    logic [WIDTH-1:0]    redirect_pc;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_pc;
    logic [INST_LEN-1:0] out_instr;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;

    // Queue side: issues fetch addresses and presents the head entry.
    modport master (
        output pc_if,
        input  instruction_if,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output count,
        output full,
        output empty
    );

    // Environment side: instruction memory, redirect source and decode.
    modport slave (
        input  pc_if,
        output instruction_if,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  count,
        input  full,
        input  empty
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a sequential fetch PC feeds {pc, instr} pairs
// into a circular buffer drained by decode. A redirect flushes the queue
// and restarts fetching from the target address on the following edge.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               INST_LEN = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    fetch_queue_if.master  fq
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);

    logic [WIDTH-1:0]    fpc;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    cnt;

    // Entry storage is data only; the pointers and count decide validity.
    logic [WIDTH-1:0]    pc_mem    [DEPTH];
    logic [INST_LEN-1:0] instr_mem [DEPTH];

    logic empty_w;
    logic full_w;
    logic pop;
    logic push;

    // Handshake decode; a redirect suppresses both push and pop.
    always_comb begin
        empty_w = (cnt == '0);
        full_w  = (cnt == FULL_CNT);
        pop     = ~empty_w & fq.out_ready & ~fq.redirect_valid;
        push    = ~fq.redirect_valid & (~full_w | pop);
    end

    assign fq.pc_if     = fpc;
    assign fq.out_valid = ~empty_w;
    assign fq.out_pc    = empty_w ? '0 : pc_mem[head];
    assign fq.out_instr = empty_w ? '0 : instr_mem[head];
    assign fq.count     = cnt;
    assign fq.full      = full_w;
    assign fq.empty     = empty_w;

    // Control state: fetch PC, pointers and occupancy; redirect has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc  <= RESET_PC;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (fq.redirect_valid) begin
            fpc  <= fq.redirect_pc;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                fpc  <= fpc + PC_STEP;
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Entry write at the tail; stale contents are harmless once flushed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= fpc;
            instr_mem[tail] <= fq.instruction_if;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a transaction-level queue model acts as scoreboard;
// expected {pc, instr} pairs are enqueued as fetches happen and compared
// against the DUT head whenever decode accepts it.
module tb_fetch_queue;
    localparam int          WIDTH    = 32;
    localparam int          INST_LEN = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic   clk = 1'b0;
    logic   reset;
    int     total = 0;
    int     bad   = 0;
    entry_t mq[$];
    logic [31:0] mfpc;

    fetch_queue_if #(.WIDTH(WIDTH), .INST_LEN(INST_LEN), .DEPTH(DEPTH)) fq();

    fetch_queue #(
        .WIDTH(WIDTH), .INST_LEN(INST_LEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fq(fq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    assign fq.instruction_if = imem(fq.pc_if);

    // Advance the reference model by one clock edge using current inputs.
    task automatic model_edge();
        bit p;
        bit q;
        if (reset) begin
            mq.delete();
            mfpc = RESET_PC;
            return;
        end
        if (fq.redirect_valid) begin
            mq.delete();
            mfpc = fq.redirect_pc;
            return;
        end
        q = (mq.size() != 0) && fq.out_ready;
        p = (mq.size() < DEPTH) || q;
        if (q) void'(mq.pop_front());
        if (p) begin
            mq.push_back('{pc: mfpc, instr: imem(mfpc)});
            mfpc = mfpc + 32'd4;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fq.redirect_valid = 1'b0;
        fq.redirect_pc = 32'h0;
        fq.out_ready = 1'b0;
        mq.delete();
        mfpc = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (fq.pc_if !== RESET_PC || fq.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_pc_valid: got pc_if=%h out_valid=%b, exp %h 0", fq.pc_if, fq.out_valid, RESET_PC);
        end
        total++;
        if (fq.out_pc !== 32'h0 || fq.out_instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_head: got out_pc=%h out_instr=%h, exp 0 0", fq.out_pc, fq.out_instr);
        end
        total++;
        if (fq.count !== 3'd0 || fq.full !== 1'b0 || fq.empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_status: got count=%0d full=%b empty=%b, exp 0 0 1", fq.count, fq.full, fq.empty);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        fq.out_ready = 1'b0;
        repeat (4) cyc();
        total++;
        if (fq.count !== 3'd4 || fq.full !== 1'b1 || fq.count !== 3'(mq.size())) begin
            bad++;
            $display("FAIL fill_count: got count=%0d full=%b, exp 4 1", fq.count, fq.full);
        end
        total++;
        if (fq.pc_if !== 32'h10 || fq.out_pc !== 32'h0 || fq.out_instr !== imem(32'h0)) begin
            bad++;
            $display("FAIL fill_head: got pc_if=%h out_pc=%h out_instr=%h, exp 10 0 %h", fq.pc_if, fq.out_pc, fq.out_instr, imem(32'h0));
        end
        cyc();
        total++;
        if (fq.pc_if !== 32'h10 || fq.count !== 3'd4) begin
            bad++;
            $display("FAIL fill_hold: got pc_if=%h count=%0d, exp 10 4", fq.pc_if, fq.count);
        end
    endtask

    task automatic test_full_push_pop();
        fq.out_ready = 1'b1;
        total++;
        if (fq.out_pc !== mq[0].pc || fq.out_instr !== mq[0].instr) begin
            bad++;
            $display("FAIL fpp_pop: got pc=%h instr=%h, exp pc=%h instr=%h", fq.out_pc, fq.out_instr, mq[0].pc, mq[0].instr);
        end
        cyc();
        fq.out_ready = 1'b0;
        total++;
        if (fq.count !== 3'd4 || fq.out_pc !== 32'h4 || fq.pc_if !== 32'h14) begin
            bad++;
            $display("FAIL fpp_state: got count=%0d out_pc=%h pc_if=%h, exp 4 4 14", fq.count, fq.out_pc, fq.pc_if);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            total++;
            if (fq.out_pc !== 32'h4 || fq.out_instr !== imem(32'h4) || fq.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold: got out_pc=%h out_valid=%b, exp 4 1", fq.out_pc, fq.out_valid);
            end
        end
    endtask

    task automatic test_redirect_full();
        fq.redirect_valid = 1'b1;
        fq.redirect_pc = 32'h100;
        fq.out_ready = 1'b1;
        cyc();
        fq.redirect_valid = 1'b0;
        fq.out_ready = 1'b0;
        total++;
        if (fq.count !== 3'd0 || fq.out_valid !== 1'b0 || fq.empty !== 1'b1 || fq.pc_if !== 32'h100 || fq.out_pc !== 32'h0) begin
            bad++;
            $display("FAIL redir_flush: got count=%0d out_valid=%b pc_if=%h out_pc=%h, exp 0 0 100 0", fq.count, fq.out_valid, fq.pc_if, fq.out_pc);
        end
        cyc();
        total++;
        if (fq.out_valid !== 1'b1 || fq.out_pc !== 32'h100 || fq.out_instr !== imem(32'h100) || fq.count !== 3'd1) begin
            bad++;
            $display("FAIL redir_first: got out_valid=%b out_pc=%h count=%0d, exp 1 100 1", fq.out_valid, fq.out_pc, fq.count);
        end
    endtask

    task automatic test_streaming();
        fq.redirect_valid = 1'b1;
        fq.redirect_pc = 32'h0;
        fq.out_ready = 1'b1;
        cyc();
        fq.redirect_valid = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (fq.count !== 3'd1 || fq.out_pc !== 32'(4 * i)) begin
                bad++;
                $display("FAIL stream_seq[%0d]: got count=%0d out_pc=%h, exp 1 %h", i, fq.count, fq.out_pc, 32'(4 * i));
            end
            if (mq.size() != 0) begin
                total++;
                if (fq.out_pc !== mq[0].pc || fq.out_instr !== mq[0].instr) begin
                    bad++;
                    $display("FAIL stream_pop[%0d]: got pc=%h instr=%h, exp pc=%h instr=%h", i, fq.out_pc, fq.out_instr, mq[0].pc, mq[0].instr);
                end
            end
            cyc();
        end
        fq.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        fq.redirect_valid = 1'b1;
        fq.redirect_pc = 32'h200;
        cyc();
        total++;
        if (fq.pc_if !== 32'h200 || fq.empty !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: got pc_if=%h empty=%b, exp 200 1", fq.pc_if, fq.empty);
        end
        fq.redirect_pc = 32'h302;
        cyc();
        fq.redirect_valid = 1'b0;
        total++;
        if (fq.pc_if !== 32'h302 || fq.empty !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: got pc_if=%h empty=%b, exp 302 1", fq.pc_if, fq.empty);
        end
        cyc();
        total++;
        if (fq.out_pc !== 32'h302 || fq.out_instr !== imem(32'h302) || fq.pc_if !== 32'h306) begin
            bad++;
            $display("FAIL b2b_unaligned: got out_pc=%h pc_if=%h, exp 302 306", fq.out_pc, fq.pc_if);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            fq.out_ready = 1'($urandom_range(0, 1));
            fq.redirect_valid = ($urandom_range(0, 11) == 0);
            fq.redirect_pc = $urandom;
            total++;
            if (fq.count !== 3'(mq.size()) || fq.out_valid !== (mq.size() != 0) || fq.pc_if !== mfpc) begin
                bad++;
                $display("FAIL rand_state[%0d]: got count=%0d out_valid=%b pc_if=%h, exp %0d %b %h", i, fq.count, fq.out_valid, fq.pc_if, mq.size(), mq.size() != 0, mfpc);
            end
            if (mq.size() != 0 && fq.out_ready && !fq.redirect_valid) begin
                total++;
                if (fq.out_pc !== mq[0].pc || fq.out_instr !== mq[0].instr) begin
                    bad++;
                    $display("FAIL rand_pop[%0d]: got pc=%h instr=%h, exp pc=%h instr=%h", i, fq.out_pc, fq.out_instr, mq[0].pc, mq[0].instr);
                end
            end
            cyc();
        end
        fq.redirect_valid = 1'b0;
        fq.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        fq.redirect_valid = 1'b1;
        fq.redirect_pc = 32'h40;
        cyc();
        fq.redirect_valid = 1'b0;
        repeat (3) cyc();
        total++;
        if (fq.count !== 3'd3 || fq.out_pc !== 32'h40) begin
            bad++;
            $display("FAIL ar_setup: got count=%0d out_pc=%h, exp 3 40", fq.count, fq.out_pc);
        end
        #2;
        reset = 1'b1;
        mq.delete();
        mfpc = RESET_PC;
        #1;
        total++;
        if (fq.pc_if !== RESET_PC || fq.out_valid !== 1'b0 || fq.count !== 3'd0 || fq.empty !== 1'b1 || fq.full !== 1'b0) begin
            bad++;
            $display("FAIL ar_immediate: got pc_if=%h out_valid=%b count=%0d empty=%b full=%b", fq.pc_if, fq.out_valid, fq.count, fq.empty, fq.full);
        end
        total++;
        if (fq.out_pc !== 32'h0 || fq.out_instr !== 32'h0) begin
            bad++;
            $display("FAIL ar_head: got out_pc=%h out_instr=%h, exp 0 0", fq.out_pc, fq.out_instr);
        end
        @(posedge clk);
        #1;
        total++;
        if (fq.count !== 3'd0 || fq.pc_if !== RESET_PC) begin
            bad++;
            $display("FAIL ar_held: got count=%0d pc_if=%h, exp 0 %h", fq.count, fq.pc_if, RESET_PC);
        end
        reset = 1'b0;
        cyc();
        total++;
        if (fq.count !== 3'd1 || fq.out_pc !== RESET_PC || fq.pc_if !== RESET_PC + 32'd4) begin
            bad++;
            $display("FAIL ar_resume: got count=%0d out_pc=%h pc_if=%h", fq.count, fq.out_pc, fq.pc_if);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_redirect_full();
        test_streaming();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/data width in bits.
REQ-002 SHALL have parameter INST_LEN, default 32, instruction width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port pc_if  output  WIDTH  fetch address to instruction memory.
REQ-008 SHALL have port instruction_if  input  INST_LEN  instruction memory data for pc_if, valid in the same cycle.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-010 SHALL have port redirect_pc  input  WIDTH  redirect target address.
REQ-011 SHALL have port out_valid  output  1  queue head holds a valid entry.
REQ-012 SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-013 SHALL have port out_pc  output  WIDTH  PC of the head entry.
REQ-014 SHALL have port out_instr  output  INST_LEN  instruction of the head entry.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-016 SHALL have port full  output  1  count == DEPTH.
REQ-017 SHALL have port empty  output  1  count == 0.

Function
REQ-018 SHALL hold fetch PC register fpc; pc_if = fpc combinationally.
REQ-019 SHALL store entries as {pc, instr} pairs in a circular buffer with head/tail pointers of width log2(DEPTH), wrapping modulo DEPTH.
REQ-020 SHALL define pop = out_valid & out_ready & ~redirect_valid.
REQ-021 SHALL define push = ~redirect_valid & (~full | pop); push writes {fpc, instruction_if} at tail.
REQ-022 SHALL advance fpc by 4 (modulo 2^WIDTH) on push; fpc holds otherwise when no redirect.
REQ-023 SHALL present out_valid = ~empty; out_pc/out_instr = head entry, combinational from storage, zero when empty.
REQ-024 SHALL update count: +1 push only, -1 pop only, unchanged on push & pop or neither.
REQ-025 SHALL allow push and pop in the same cycle when full; count stays DEPTH, oldest entry leaves, new entry enters.
REQ-026 SHALL, on redirect_valid, in the same edge: set head = tail = 0, count = 0, fpc = redirect_pc; no push, no pop that cycle.
REQ-027 SHALL give redirect priority over push, pop and out_ready; out_valid is 0 in the cycle after a redirect.
REQ-028 SHALL resume pushing from redirect_pc in the cycle after a redirect; first entry visible at out_valid two edges after redirect assertion.
REQ-029 SHALL have one-cycle latency from push edge to entry visibility at the head when empty (no bypass).
REQ-030 SHALL keep the head entry stable while out_valid & ~out_ready.
REQ-031 SHALL accept back-to-back redirects; each redirect overrides the previous fpc.
REQ-032 SHALL not check alignment of redirect_pc; low bits are passed through unchanged.

Reset
REQ-033 SHALL, on reset assertion, asynchronously set fpc = RESET_PC, head = tail = 0, count = 0.
REQ-034 SHALL drive, during reset: pc_if = RESET_PC, out_valid = 0, out_pc = 0, out_instr = 0, count = 0, full = 0, empty = 1.
REQ-035 SHALL discard all queued entries on reset mid-operation; storage contents need not be cleared.
REQ-036 SHALL begin pushing on the first rising edge after reset deassertion.

Verification
REQ-037 SHALL cover fill: out_ready=0, sequential imem, RESET_PC=0 -> after 4 edges count=4, full=1, pc_if=0x10 held, head out_pc=0x0.
REQ-038 SHALL cover streaming: out_ready=1 continuous -> out_pc sequence 0x0,0x4,0x8,... one per cycle, count stays 1.
REQ-039 SHALL cover full with simultaneous push/pop: full, out_ready=1 one cycle -> count=4, head advances to 0x4, tail entry pc=0x10.
REQ-040 SHALL cover redirect while full: redirect_valid=1, redirect_pc=0x100 -> next cycle count=0, out_valid=0, pc_if=0x100; following cycle out_pc=0x100.
REQ-041 SHALL cover redirect with out_ready=1 same cycle -> head entry not consumed as pop; queue flushed.
REQ-042 SHALL cover asynchronous reset mid-stream with count=3 -> outputs immediately at reset values, pc_if=RESET_PC before next edge.
